usi_spi_slave_resp: RTL

- Synthesisable, parametrised SPI slave responder for USI SPI-master verification and loopback.
- Oversamples SCK, CS_B and MOSI in the system clock domain.
- Drives MISO from a selectable word source: rotating pattern, echo of received data, or a fixed pattern.
- Captures received words into a small FIFO with a valid/ready interface.
- Supports all four CPOL/CPHA modes and a parametrised word width.

---
 rtl/usi_spi_slave_resp.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/usi_spi_slave_resp.sv
// SPI slave responder: oversampled SCK/CS_B/MOSI, selectable MISO word source
// (rotate/echo/fixed), RX FIFO with valid/ready, sticky overflow, frame counter.
//
// Ports:
//   clk, rst_b          system clock, synchronous active-low reset
//   cpol, cpha, mode    frame configuration, latched at frame start
//   pattern             word source for fixed mode
//   sck, cs_b, mosi     asynchronous SPI inputs
//   miso_out, miso_oe   slave data out and its drive enable
//   rx_data, rx_valid   FIFO head (0 when empty) / not-empty
//   rx_ready            pop the FIFO head
//   rx_overflow,ovf_clr sticky word-drop flag and its clear
//   frame_cnt           completed-word count
//   busy                frame active
module usi_spi_slave_resp #(
  parameter int          DATA_W        = 16,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [31:0] RESET_PATTERN = 32'h203D
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              sck,
  input  logic              cs_b,
  input  logic              mosi,
  output logic              miso_out,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overflow,
  input  logic              ovf_clr,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] RST_PAT = RESET_PATTERN[DATA_W-1:0];

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [1:0] sck_q, cs_q, mosi_q, prim_q;
  logic       sck_prev, cs_prev, armed;
  logic       sck_s, cs_s, mosi_s;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sck_q    <= '0;
      cs_q     <= '1;
      mosi_q   <= '0;
      prim_q   <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
      armed    <= 1'b0;
    end else begin
      sck_q    <= {sck_q[0], sck};
      cs_q     <= {cs_q[0], cs_b};
      mosi_q   <= {mosi_q[0], mosi};
      prim_q   <= {prim_q[0], 1'b1};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      // prim_q[1] masks the synchroniser reset value so only a real
      // high level on cs_b can arm the first frame.
      armed    <= armed | (prim_q[1] & cs_s);
    end
  end

  assign sck_s  = sck_q[1];
  assign cs_s   = cs_q[1];
  assign mosi_s = mosi_q[1];

  logic cs_fall, cs_rise;
  assign cs_fall = cs_prev & ~cs_s;
  assign cs_rise = ~cs_prev & cs_s;

  logic start, stop;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic              cpol_f, cpha_f;
  logic [1:0]        mode_f;
  logic [BW-1:0]     bit_cnt;
  logic              samp_flag, reload;
  logic [DATA_W-1:0] tx_q, rot_q, echo_q;
  logic [DATA_W-2:0] rx_shift;

  logic active, sck_edge, lead, trail, samp, shft;
  logic last_bit, word_done, rot_f;
  logic [DATA_W-1:0] rx_word, load_now, load_frame;

  assign active   = (state_q == ACTIVE);
  assign sck_edge = sck_s ^ sck_prev;
  assign lead     = sck_edge & (sck_prev == cpol_f);
  assign trail    = sck_edge & (sck_s == cpol_f);
  assign samp     = active & ~stop & (cpha_f ? trail : lead);
  assign shft     = active & ~stop & (cpha_f ? lead : trail);
  assign last_bit = (bit_cnt == BW'(DATA_W - 1));
  assign word_done = samp & last_bit;
  assign rx_word  = {rx_shift, mosi_s};
  assign rot_f    = (mode_f == 2'b00);

  assign load_now   = (mode == 2'b01) ? echo_q : pattern;
  assign load_frame = (mode_f == 2'b01) ? echo_q : pattern;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cpol_f    <= 1'b0;
      cpha_f    <= 1'b0;
      mode_f    <= 2'b00;
      bit_cnt   <= '0;
      samp_flag <= 1'b0;
      reload    <= 1'b0;
      tx_q      <= '0;
      rot_q     <= RST_PAT;
      echo_q    <= '0;
      rx_shift  <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cpol_f    <= cpol;
        cpha_f    <= cpha;
        mode_f    <= mode;
        bit_cnt   <= '0;
        samp_flag <= 1'b0;
        reload    <= 1'b0;
        tx_q      <= load_now;
      end
      if (stop) begin
        bit_cnt <= '0;
      end
      if (samp) begin
        rx_shift  <= rx_word[DATA_W-2:0];
        samp_flag <= 1'b1;
        if (last_bit) begin
          bit_cnt   <= '0;
          echo_q    <= rx_word;
          frame_cnt <= frame_cnt + 16'd1;
          reload    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
      // In rotate mode the rotate register is the shifter itself and is
      // never reloaded, so MISO is one continuous cyclic stream.
      if (shft && samp_flag) begin
        reload <= 1'b0;
        if (rot_f) begin
          rot_q <= {rot_q[DATA_W-2:0], rot_q[DATA_W-1]};
        end else if (reload) begin
          tx_q <= load_frame;
        end else begin
          tx_q <= tx_q << 1;
        end
      end
    end
  end

  assign miso_oe  = active;
  assign busy     = active;
  assign miso_out = active & (rot_f ? rot_q[DATA_W-1] : tx_q[DATA_W-1]);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, push_ok, drop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  assign push_ok  = word_done & (~full | pop);
  assign drop     = word_done & full & ~pop;
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)         rx_overflow <= 1'b1;
      else if (ovf_clr) rx_overflow <= 1'b0;
    end
  end

endmodule
